fifo_tx_drain: RTL

Read-side consumer for the async FIFO. It runs in the read/TX clock domain. When enabled, it pops one word at a time from the FIFO's read port (EMPTY, RD_DATA, R_INC). Each word is handed to the UART transmitter through a DATA_VALID pulse, and the next pop waits until the TX BUSY cycle completes. It also keeps a transmitted-word count and a sticky timeout error for a TX that never acknowledges.

---
 rtl/fifo_tx_drain_pkg.sv | 19 +
 rtl/fifo_tx_drain.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fifo_tx_drain_pkg.sv
// ============================================================================
// Module  : fifo_tx_drain_pkg
// Brief   : Shared state encoding for the FIFO-to-UART drain engine.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fifo_tx_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_WAIT_RISE = 2'b10,
        ST_WAIT_FALL = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_tx_drain.sv
// ============================================================================
// Module  : fifo_tx_drain
// Brief   : Pops async-FIFO words one at a time and hands each to the UART TX,
//           pacing on the TX busy cycle; counts sent words, flags TX timeouts.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fifo_tx_drain
    import fifo_tx_drain_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    output logic                  o_fifo_r_inc,
    input  logic                  i_tx_busy,
    output logic [DATA_WIDTH-1:0] o_tx_p_data,
    output logic                  o_tx_data_valid,
    input  logic                  i_clr_err,
    output logic [CNT_WIDTH-1:0]  o_tx_cnt,
    output logic                  o_timeout_err
);

    localparam int                  c_to_width = $clog2(BUSY_TIMEOUT);
    localparam logic [c_to_width-1:0] c_to_last = c_to_width'(BUSY_TIMEOUT - 1);

    state_t                  r_state,     w_state;
    logic [c_to_width-1:0]   r_to_cnt,    w_to_cnt;
    logic [DATA_WIDTH-1:0]   r_tx_p_data, w_tx_p_data;
    logic                    r_fifo_r_inc, w_fifo_r_inc;
    logic                    r_tx_valid,  w_tx_valid;
    logic [CNT_WIDTH-1:0]    r_tx_cnt,    w_tx_cnt;
    logic                    r_timeout_err, w_timeout_err;
    logic                    w_set_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_to_cnt      <= '0;
            r_tx_p_data   <= '0;
            r_fifo_r_inc  <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_to_cnt      <= w_to_cnt;
            r_tx_p_data   <= w_tx_p_data;
            r_fifo_r_inc  <= w_fifo_r_inc;
            r_tx_valid    <= w_tx_valid;
            r_tx_cnt      <= w_tx_cnt;
            r_timeout_err <= w_timeout_err;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_to_cnt     = r_to_cnt;
        w_tx_p_data  = r_tx_p_data;
        w_fifo_r_inc = 1'b0;
        w_tx_valid   = 1'b0;
        w_tx_cnt     = r_tx_cnt;
        w_set_err    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Pop and start TX in the same edge; data stays held until the next pop.
                if (i_enable && !i_fifo_empty && !i_tx_busy) begin
                    w_tx_p_data  = i_fifo_rd_data;
                    w_fifo_r_inc = 1'b1;
                    w_tx_valid   = 1'b1;
                    w_state      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_to_cnt = '0;
                w_state  = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (i_tx_busy) begin
                    w_state = ST_WAIT_FALL;
                end else if (r_to_cnt == c_to_last) begin
                    w_set_err = 1'b1;
                    w_state   = ST_IDLE;
                end else begin
                    w_to_cnt = r_to_cnt + c_to_width'(1);
                end
            end
            ST_WAIT_FALL: begin
                if (!i_tx_busy) begin
                    w_tx_cnt = r_tx_cnt + CNT_WIDTH'(1);
                    w_state  = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // A fresh timeout takes priority over a same-cycle clear.
        if (w_set_err) begin
            w_timeout_err = 1'b1;
        end else if (i_clr_err) begin
            w_timeout_err = 1'b0;
        end else begin
            w_timeout_err = r_timeout_err;
        end
    end

    assign o_fifo_r_inc    = r_fifo_r_inc;
    assign o_tx_data_valid = r_tx_valid;
    assign o_tx_p_data     = r_tx_p_data;
    assign o_tx_cnt        = r_tx_cnt;
    assign o_timeout_err   = r_timeout_err;

endmodule

`default_nettype wire
